// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the multi-cycle RV32 memory stage:
// width codes, FSM states, store lane alignment and load extension.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } store_lanes_t;

  function automatic store_lanes_t store_align(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] d);
    store_lanes_t s;
    case (f3)
      F3_B:    begin s.be = 4'b0001 << off; s.data = {4{d[7:0]}};  end
      F3_H:    begin s.be = 4'b0011 << off; s.data = {2{d[15:0]}}; end
      default: begin s.be = 4'b1111;        s.data = d;            end
    endcase
    return s;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_BU:   return {24'h0, sh[7:0]};
      F3_HU:   return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic is_illegal(input logic rd, input logic wr, input logic [2:0] f3);
    if (rd == wr) return 1'b1;
    if (rd)       return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    return !(f3 inside {F3_B, F3_H, F3_W});
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
module mem_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic          i_re,
  input  logic [IW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  // NOTE: the array has no reset; clearing it would force flops instead of RAM macros.
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage_pipe.sv
// Multi-cycle RV32 load/store stage: valid/ready request, fixed-latency response,
// byte-lane alignment, sign/zero extension and error flagging.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           rs2_data,
  output logic                  resp_valid,
  output logic [31:0]           load_data_out,
  output logic                  misaligned,
  output logic                  illegal,
  output logic                  stall
);

  localparam int         IW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_cnt;
  logic           r_rd, r_wr;
  logic [2:0]     r_f3;
  logic [IW+1:0]  r_addr;
  logic [31:0]    r_wdata;

  logic           w_accept, w_busy, w_enter_resp, w_err;
  logic           w_rd, w_wr;
  logic [2:0]     w_f3;
  logic [IW+1:0]  w_addr;
  logic [31:0]    w_wdata, w_rdata;
  logic           w_r_ill, w_r_mis;
  store_lanes_t   w_lanes;
  logic           w_unused;

  assign w_unused  = &{1'b0, addr[ADDR_WIDTH-1:IW+2]};
  assign w_busy    = (r_state == BUSY);
  assign req_ready = ~w_busy;
  assign stall     = req_valid & ~req_ready;
  assign w_accept  = req_valid & req_ready;

  // The RAM acts at the edge entering RESP: live inputs when that edge is the
  // accept edge (LATENCY == 1), otherwise the request captured at accept.
  assign w_rd    = w_busy ? r_rd    : mem_read;
  assign w_wr    = w_busy ? r_wr    : mem_write;
  assign w_f3    = w_busy ? r_f3    : funct3;
  assign w_addr  = w_busy ? r_addr  : addr[IW+1:0];
  assign w_wdata = w_busy ? r_wdata : rs2_data;

  assign w_err        = is_illegal(w_rd, w_wr, w_f3) | is_misaligned(w_f3, w_addr[1:0]);
  assign w_enter_resp = ~rst & ((w_accept & (LATENCY == 1)) | (w_busy & (r_cnt == 4'd1)));
  assign w_lanes      = store_align(w_f3, w_addr[1:0], w_wdata);

  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .i_we    (w_enter_resp & w_wr & ~w_err),
    .i_be    (w_lanes.be),
    .i_re    (w_enter_resp & w_rd & ~w_err),
    .i_addr  (w_addr[IW+1:2]),
    .i_wdata (w_lanes.data),
    .o_rdata (w_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (r_cnt == 4'd1) w_state_nxt = RESP;
      RESP:    if (w_accept) w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
               else          w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_cnt   <= CNT_INIT;
      r_rd    <= mem_read;
      r_wr    <= mem_write;
      r_f3    <= funct3;
      r_addr  <= addr[IW+1:0];
      r_wdata <= rs2_data;
    end else if (w_busy) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  assign w_r_ill = is_illegal(r_rd, r_wr, r_f3);
  assign w_r_mis = is_misaligned(r_f3, r_addr[1:0]);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    resp_valid    = 1'b0;
    misaligned    = 1'b0;
    illegal       = 1'b0;
    load_data_out = 32'd0;
    if (r_state == RESP) begin
      resp_valid = 1'b1;
      illegal    = w_r_ill;
      misaligned = ~w_r_ill & w_r_mis;
      if (r_rd & ~w_r_ill & ~w_r_mis) load_data_out = load_extend(r_f3, r_addr[1:0], w_rdata);
    end
  end

endmodule
